// File: rtl/arcade_input_pkg.sv
// Shared constants, types and the rotation helper for the arcade input mapper.
// Joystick and CSJUDLR bit positions are fixed by the cores this block feeds.
package arcade_input_pkg;

    // Joystick word bit positions (low byte of each 16-bit player word)
    localparam int JB_R      = 0;
    localparam int JB_L      = 1;
    localparam int JB_D      = 2;
    localparam int JB_U      = 3;
    localparam int JB_FIRE   = 4;
    localparam int JB_START1 = 5;
    localparam int JB_START2 = 6;
    localparam int JB_COIN   = 7;

    // CSJUDLR output field positions
    localparam int CS_R     = 0;
    localparam int CS_L     = 1;
    localparam int CS_D     = 2;
    localparam int CS_U     = 3;
    localparam int CS_FIRE  = 4;
    localparam int CS_START = 5;
    localparam int CS_COIN  = 6;
    localparam int CS_W     = 7;

    typedef enum logic [1:0] {ROT0, ROT90, ROT180, ROT270} rot_t;

    typedef enum logic [1:0] {C_IDLE, C_PULSE, C_WAIT} coin_st_t;

    // PS/2 scancodes as {extended, code}
    localparam logic [8:0] SC_UP    = 9'h175;
    localparam logic [8:0] SC_DOWN  = 9'h172;
    localparam logic [8:0] SC_LEFT  = 9'h16B;
    localparam logic [8:0] SC_RIGHT = 9'h174;
    localparam logic [8:0] SC_SPACE = 9'h029;
    localparam logic [8:0] SC_LCTRL = 9'h014;
    localparam logic [8:0] SC_RCTRL = 9'h114;
    localparam logic [8:0] SC_F1    = 9'h005;
    localparam logic [8:0] SC_F2    = 9'h006;
    localparam logic [8:0] SC_COIN1 = 9'h02E;
    localparam logic [8:0] SC_COIN2 = 9'h036;

    // One latch per physical key so that releasing one of two fire keys
    // does not cancel the other.
    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic space;
        logic lctrl;
        logic rctrl;
        logic f1;
        logic f2;
        logic coin1;
        logic coin2;
    } key_state_t;

    // udlr packing is {up, down, left, right}, matching both joystick [3:0]
    // and CSJUDLR [3:0].
    function automatic logic [3:0] rotate_udlr(input rot_t rot, input logic [3:0] udlr);
        logic [3:0] res;
        res = udlr;
        case (rot)
            ROT0:    res = udlr;
            ROT90:   res = {udlr[1], udlr[0], udlr[2], udlr[3]};
            ROT180:  res = {udlr[2], udlr[3], udlr[0], udlr[1]};
            ROT270:  res = {udlr[0], udlr[1], udlr[3], udlr[2]};
            default: res = udlr;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/input_player_chan.sv
// One player's output channel: rotation, fixed-length coin pulse and autofire,
// all landing in the registered CSJUDLR vector.
module input_player_chan
    import arcade_input_pkg::*;
#(
    parameter int COIN_PULSE   = 16,
    parameter int AUTOFIRE_DIV = 4096
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic [3:0]      raw_udlr,
    input  logic            raw_fire,
    input  logic            start,
    input  logic            coin_src,
    input  rot_t            rot,
    input  logic            autofire_en,
    output logic [CS_W-1:0] csjudlr
);

    localparam logic [15:0] COIN_LOAD = 16'(COIN_PULSE - 1);
    localparam logic [15:0] AF_LAST   = 16'(AUTOFIRE_DIV - 1);

    logic [3:0]  udlr_q, udlr_d;
    logic        start_q, start_d;
    coin_st_t    coin_st_q, coin_st_d;
    logic [15:0] coin_cnt_q, coin_cnt_d;
    logic        coin_q, coin_d;
    logic        coin_src_prev_q, coin_src_prev_d;
    logic        fire_prev_q, fire_prev_d;
    logic        af_phase_q, af_phase_d;
    logic [15:0] af_cnt_q, af_cnt_d;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        udlr_d          = rotate_udlr(rot, raw_udlr);
        start_d         = start;
        coin_src_prev_d = coin_src;
        fire_prev_d     = raw_fire;
    end

    always_comb begin
        coin_st_d  = coin_st_q;
        coin_cnt_d = coin_cnt_q;
        case (coin_st_q)
            C_IDLE: begin
                if (coin_src && !coin_src_prev_q) begin
                    coin_st_d  = C_PULSE;
                    coin_cnt_d = COIN_LOAD;
                end
            end
            C_PULSE: begin
                if (coin_cnt_q == 16'd0) begin
                    coin_st_d = C_WAIT;
                end else begin
                    coin_cnt_d = coin_cnt_q - 16'd1;
                end
            end
            C_WAIT: begin
                if (!coin_src) begin
                    coin_st_d = C_IDLE;
                end
            end
            default: coin_st_d = C_WAIT;
        endcase
        coin_d = (coin_st_d == C_PULSE);
    end

    // Phase doubles as the fire flop: with autofire off it simply follows raw fire.
    always_comb begin
        af_phase_d = af_phase_q;
        af_cnt_d   = af_cnt_q;
        if (!raw_fire) begin
            af_phase_d = 1'b0;
            af_cnt_d   = 16'd0;
        end else if (!autofire_en || !fire_prev_q) begin
            af_phase_d = 1'b1;
            af_cnt_d   = 16'd0;
        end else if (af_cnt_q == AF_LAST) begin
            af_phase_d = ~af_phase_q;
            af_cnt_d   = 16'd0;
        end else begin
            af_cnt_d = af_cnt_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            udlr_q          <= 4'd0;
            start_q         <= 1'b0;
            // Waiting-for-release after reset: a coin held through reset must
            // not fire a fresh pulse until it is released and pressed again.
            coin_st_q       <= C_WAIT;
            coin_cnt_q      <= 16'd0;
            coin_q          <= 1'b0;
            coin_src_prev_q <= 1'b0;
            fire_prev_q     <= 1'b0;
            af_phase_q      <= 1'b0;
            af_cnt_q        <= 16'd0;
        end else begin
            udlr_q          <= udlr_d;
            start_q         <= start_d;
            coin_st_q       <= coin_st_d;
            coin_cnt_q      <= coin_cnt_d;
            coin_q          <= coin_d;
            coin_src_prev_q <= coin_src_prev_d;
            fire_prev_q     <= fire_prev_d;
            af_phase_q      <= af_phase_d;
            af_cnt_q        <= af_cnt_d;
        end
    end

    assign csjudlr = {coin_q, start_q, af_phase_q, udlr_q};

endmodule

// File: rtl/arcade_input_mapper.sv
// Player-input front end: PS/2 key latches merged with HPS joysticks, then one
// input_player_chan per player producing a registered CSJUDLR vector.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int COIN_PULSE   = 16,
    parameter int AUTOFIRE_DIV = 4096
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [10:0]               ps2_key,
    input  logic [16*NUM_PLAYERS-1:0] joy_in,
    input  logic [1:0]                rotate,
    input  logic                      coin_on_start,
    input  logic                      autofire_en,
    output logic [7*NUM_PLAYERS-1:0]  p_csjudlr
);

    logic       strobe_q, strobe_d;
    logic       armed_q, armed_d;
    key_state_t keys_q, keys_d;
    logic       key_event;
    logic       start1_any, start2_any;
    rot_t       rot;

    // The strobe is a toggle; the first sample after reset only arms the tracker.
    assign key_event = armed_q && (ps2_key[10] != strobe_q);
    assign rot       = rot_t'(rotate);

    always_comb begin
        armed_d  = 1'b1;
        strobe_d = ps2_key[10];
        keys_d   = keys_q;
        if (key_event) begin
            case (ps2_key[8:0])
                SC_UP:    keys_d.up    = ps2_key[9];
                SC_DOWN:  keys_d.down  = ps2_key[9];
                SC_LEFT:  keys_d.left  = ps2_key[9];
                SC_RIGHT: keys_d.right = ps2_key[9];
                SC_SPACE: keys_d.space = ps2_key[9];
                SC_LCTRL: keys_d.lctrl = ps2_key[9];
                SC_RCTRL: keys_d.rctrl = ps2_key[9];
                SC_F1:    keys_d.f1    = ps2_key[9];
                SC_F2:    keys_d.f2    = ps2_key[9];
                SC_COIN1: keys_d.coin1 = ps2_key[9];
                SC_COIN2: keys_d.coin2 = ps2_key[9];
                default:  keys_d       = keys_q;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            strobe_q <= 1'b0;
            armed_q  <= 1'b0;
            keys_q   <= '0;
        end else begin
            strobe_q <= strobe_d;
            armed_q  <= armed_d;
            keys_q   <= keys_d;
        end
    end

    // Any joystick's start buttons count for players 1 and 2.
    always_comb begin
        start1_any = keys_q.f1;
        start2_any = keys_q.f2;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            start1_any = start1_any | joy_in[16*p + JB_START1];
            start2_any = start2_any | joy_in[16*p + JB_START2];
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [7:0] joy;
        logic [3:0] raw_udlr;
        logic       raw_fire;
        logic       start_p;
        logic       coin_key;
        logic       coin_src;
        logic       unused_joy_hi;

        assign joy           = joy_in[16*p +: 8];
        assign unused_joy_hi = ^joy_in[16*p + 8 +: 8];

        if (p == 0) begin : g_p1
            assign raw_udlr = joy[JB_U:JB_R] | {keys_q.up, keys_q.down, keys_q.left, keys_q.right};
            assign raw_fire = joy[JB_FIRE] | keys_q.space | keys_q.lctrl | keys_q.rctrl;
            assign start_p  = start1_any;
            assign coin_key = keys_q.coin1;
        end else if (p == 1) begin : g_p2
            assign raw_udlr = joy[JB_U:JB_R];
            assign raw_fire = joy[JB_FIRE];
            assign start_p  = start2_any;
            assign coin_key = keys_q.coin2;
        end else begin : g_pn
            assign raw_udlr = joy[JB_U:JB_R];
            assign raw_fire = joy[JB_FIRE];
            assign start_p  = 1'b0;
            assign coin_key = 1'b0;
        end

        assign coin_src = joy[JB_COIN] | coin_key | (coin_on_start & start_p);

        input_player_chan #(
            .COIN_PULSE   (COIN_PULSE),
            .AUTOFIRE_DIV (AUTOFIRE_DIV)
        ) u_chan (
            .clk_sys     (clk_sys),
            .reset       (reset),
            .raw_udlr    (raw_udlr),
            .raw_fire    (raw_fire),
            .start       (start_p),
            .coin_src    (coin_src),
            .rot         (rot),
            .autofire_en (autofire_en),
            .csjudlr     (p_csjudlr[CS_W*p +: CS_W])
        );
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench for arcade_input_mapper: directed scenarios plus random
// stimulus, all checked against a cycle-level behavioural model.
module tb_arcade_input_mapper;

    localparam int NP = 3;
    localparam int CP = 16;
    localparam int AD = 4;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic [10:0]       ps2_key;
    logic [16*NP-1:0]  joy_in;
    logic [1:0]        rotate;
    logic              coin_on_start;
    logic              autofire_en;
    logic [7*NP-1:0]   p_csjudlr;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(
        .NUM_PLAYERS  (NP),
        .COIN_PULSE   (CP),
        .AUTOFIRE_DIV (AD)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ps2_key       (ps2_key),
        .joy_in        (joy_in),
        .rotate        (rotate),
        .coin_on_start (coin_on_start),
        .autofire_en   (autofire_en),
        .p_csjudlr     (p_csjudlr)
    );

    // Reference model state
    bit         key_down [512];
    bit         kb_armed;
    bit         strobe_last;
    int         pulse_left [NP];
    bit         waiting    [NP];
    bit         src_last   [NP];
    int         held       [NP];
    bit         fire_last  [NP];
    logic [6:0] exp_vec    [NP];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 512; i++) key_down[i] = 1'b0;
        kb_armed    = 1'b0;
        strobe_last = 1'b0;
        for (int p = 0; p < NP; p++) begin
            pulse_left[p] = 0;
            waiting[p]    = 1'b1;
            src_last[p]   = 1'b0;
            held[p]       = 0;
            fire_last[p]  = 1'b0;
            exp_vec[p]    = 7'd0;
        end
    endtask

    // Outputs after this edge come from the pre-edge key state; keys update last.
    task automatic model_step();
        bit any5, any6;
        any5 = 1'b0;
        any6 = 1'b0;
        for (int p = 0; p < NP; p++) begin
            any5 |= joy_in[16*p + 5];
            any6 |= joy_in[16*p + 6];
        end
        for (int p = 0; p < NP; p++) begin
            bit [7:0] j;
            bit [3:0] ring;
            bit [3:0] turned;
            bit       fire, start, src, fire_out, kb;
            j  = joy_in[16*p +: 8];
            kb = (p == 0);
            // Directions on a clockwise ring: 0 up, 1 right, 2 down, 3 left.
            ring[0] = j[3] | (kb & key_down[9'h175]);
            ring[1] = j[0] | (kb & key_down[9'h174]);
            ring[2] = j[2] | (kb & key_down[9'h172]);
            ring[3] = j[1] | (kb & key_down[9'h16B]);
            for (int i = 0; i < 4; i++) turned[i] = ring[(i - int'(rotate) + 4) % 4];
            fire  = j[4] | (kb & (key_down[9'h029] | key_down[9'h014] | key_down[9'h114]));
            start = (p == 0) ? (any5 | key_down[9'h005]) :
                    (p == 1) ? (any6 | key_down[9'h006]) : 1'b0;
            src   = j[7] | (kb & key_down[9'h02E]) | ((p == 1) & key_down[9'h036]) |
                    (coin_on_start & start);

            if (pulse_left[p] > 0) begin
                pulse_left[p]--;
                if (pulse_left[p] == 0) waiting[p] = 1'b1;
            end else if (waiting[p]) begin
                if (!src) waiting[p] = 1'b0;
            end else if (src && !src_last[p]) begin
                pulse_left[p] = CP;
            end
            src_last[p] = src;

            if (!fire) begin
                fire_out = 1'b0;
            end else if (!autofire_en) begin
                held[p]  = 0;
                fire_out = 1'b1;
            end else begin
                if (!fire_last[p]) held[p] = 0;
                else               held[p]++;
                fire_out = ((held[p] / AD) % 2) == 0;
            end
            fire_last[p] = fire;

            exp_vec[p] = {pulse_left[p] > 0, start, fire_out, turned[0], turned[2], turned[3], turned[1]};
        end
        if (!kb_armed) begin
            kb_armed    = 1'b1;
            strobe_last = ps2_key[10];
        end else if (ps2_key[10] != strobe_last) begin
            strobe_last          = ps2_key[10];
            key_down[ps2_key[8:0]] = ps2_key[9];
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        if (reset) model_reset();
        else       model_step();
        #1;
        for (int p = 0; p < NP; p++)
            check($sformatf("p%0d_vec", p), 32'(p_csjudlr[7*p +: 7]), 32'(exp_vec[p]));
    endtask

    task automatic key(input bit pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
    endtask

    task automatic set_joy(input int p, input logic [7:0] val);
        joy_in[16*p +: 16] = {8'd0, val};
    endtask

    task automatic count_coin(input int p, input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (p_csjudlr[7*p + 6]) hi++;
        end
    endtask

    logic [3:0]  rot_exp [4];
    logic [8:0]  codes   [14];
    logic [19:0] pat;
    int          hi, hi2, rst_hold;

    initial begin
        rot_exp = '{4'b1000, 4'b0001, 4'b0100, 4'b0010};
        codes   = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h029, 9'h014, 9'h114,
                    9'h005, 9'h006, 9'h02E, 9'h036, 9'h075, 9'h01C, 9'h1D5};

        reset         = 1'b1;
        ps2_key       = 11'h400;
        joy_in        = '0;
        rotate        = 2'd0;
        coin_on_start = 1'b0;
        autofire_en   = 1'b0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_all_zero", 32'(p_csjudlr), 32'd0);

        // Keyboard up arrow: latch one cycle, output the next
        key(1'b1, 9'h175);
        tick();
        check("kb_up_latch", 32'(p_csjudlr[6:0]), 32'd0);
        tick();
        check("kb_up", 32'(p_csjudlr[6:0]), 32'h08);
        key(1'b0, 9'h175);
        tick();
        tick();
        check("kb_up_rel", 32'(p_csjudlr[6:0]), 32'd0);

        // Rotation of joystick up
        set_joy(0, 8'h08);
        for (int r = 0; r < 4; r++) begin
            rotate = 2'(r);
            tick();
            check($sformatf("rot%0d_udlr", r), 32'(p_csjudlr[3:0]), 32'(rot_exp[r]));
        end
        set_joy(0, 8'h00);
        rotate = 2'd0;
        tick();

        // P2 coin: long hold, re-press, re-press mid-pulse
        set_joy(1, 8'h80);
        count_coin(1, 100, hi);
        check("coin_hold_len", 32'(hi), 32'(CP));
        set_joy(1, 8'h00);
        repeat (2) tick();
        set_joy(1, 8'h80);
        count_coin(1, 40, hi);
        check("coin_repress_len", 32'(hi), 32'(CP));
        set_joy(1, 8'h00);
        repeat (2) tick();
        set_joy(1, 8'h80);
        count_coin(1, 2, hi);
        set_joy(1, 8'h00);
        count_coin(1, 2, hi2);
        hi += hi2;
        set_joy(1, 8'h80);
        count_coin(1, 40, hi2);
        check("coin_no_extend", 32'(hi + hi2), 32'(CP));
        set_joy(1, 8'h00);
        repeat (3) tick();

        // Coin-on-start via F1
        coin_on_start = 1'b1;
        key(1'b1, 9'h005);
        tick();
        count_coin(0, 40, hi);
        check("cos_coin_len", 32'(hi), 32'(CP));
        check("cos_start", 32'(p_csjudlr[5]), 32'd1);
        key(1'b0, 9'h005);
        coin_on_start = 1'b0;
        repeat (3) tick();
        key(1'b1, 9'h005);
        count_coin(0, 40, hi);
        check("nocos_coin_len", 32'(hi), 32'd0);
        check("nocos_start", 32'(p_csjudlr[5]), 32'd1);
        key(1'b0, 9'h005);
        repeat (3) tick();

        // Autofire pattern
        autofire_en = 1'b1;
        set_joy(0, 8'h10);
        pat = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            pat = {pat[18:0], p_csjudlr[4]};
        end
        check("af_pattern", 32'(pat), 32'(20'b11110000111100001111));
        set_joy(0, 8'h00);
        tick();
        check("af_release", 32'(p_csjudlr[4]), 32'd0);
        autofire_en = 1'b0;
        tick();

        // Asynchronous reset in the middle of a coin pulse
        set_joy(1, 8'h80);
        repeat (8) tick();
        check("pre_rst_coin", 32'(p_csjudlr[13]), 32'd1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rst_coin", 32'(p_csjudlr[13]), 32'd0);
        check("async_rst_all", 32'(p_csjudlr), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        count_coin(1, 30, hi);
        check("rst_no_retrig", 32'(hi), 32'd0);
        set_joy(1, 8'h00);
        repeat (2) tick();
        set_joy(1, 8'h80);
        count_coin(1, 30, hi);
        check("rst_edge_retrig", 32'(hi), 32'(CP));
        set_joy(1, 8'h00);
        repeat (2) tick();

        // Random stimulus against the model
        rst_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0)
                key(1'($urandom_range(0, 1)), codes[$urandom_range(0, 13)]);
            for (int p = 0; p < NP; p++)
                if ($urandom_range(0, 5) == 0)
                    joy_in[16*p + $urandom_range(0, 9)] ^= 1'b1;
            if ($urandom_range(0, 49) == 0) rotate = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) coin_on_start = ~coin_on_start;
            if ($urandom_range(0, 39) == 0) autofire_en = ~autofire_en;
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) reset = 1'b0;
            end else if ($urandom_range(0, 799) == 0) begin
                reset    = 1'b1;
                model_reset();
                rst_hold = 2;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
